robo_controle: RTL and testbench
================================

# robo_controle

Parametrised wall-following navigation controller for the maze robot. It runs from a single clock with internal phase sequencing, so no divided clocks are needed. It merges sensor decision, orientation tracking and advance bookkeeping into one FSM, and adds grid position tracking, a step limit and a selectable follow side. It sits between the map/sensor model (head, lateral, under, barreira) and the map update logic, which consumes avancar/girar/sentido/remover.

## Interface
- COLS, 8: grid columns; X coordinate width XW = $clog2(COLS).
- ROWS, 8: grid rows; Y coordinate width YW = $clog2(ROWS).
- X0, 0 / Y0, 0: start position.
- ORI0, 0: start orientation (0=N, 1=E, 2=S, 3=W).
- LADO, 0: follow side (0 = left-hand rule, 1 = right-hand rule).
- SETTLE_CYC, 2: wait cycles after each action so the map can update the sensors (≥1).
- PW, 8: step counter width.
- MAX_PASSOS, 255: step limit (≤ 2^PW−1).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  level; begins or restarts a run.
- head  in  1  wall ahead.
- lateral  in  1  wall on the follow side.
- barreira  in  1  obstacle ahead is removable debris.
- under  in  1  robot is on the target cell.
- avancar  out  1  one-cycle advance pulse.
- girar  out  1  one-cycle turn pulse.
- sentido  out  1  turn direction, valid with girar (0=ccw, 1=cw).
- remover  out  1  one-cycle remove-debris pulse.
- orientacao  out  2  current heading.
- pos_x  out  XW  current column.
- pos_y  out  YW  current row.
- passos  out  PW  count of avancar pulses this run.
- ocupado  out  1  high outside IDLE/DONE.
- chegou  out  1  sticky: target reached.
- timeout  out  1  sticky: step limit hit.

## Operation
- States: IDLE, SENSE, DECIDE, ACT, SETTLE, DONE.
- Reset (reset=0, async): state=IDLE, orientacao=ORI0, pos=(X0,Y0), passos=0, pend=0, and all pulses, ocupado, chegou and timeout are 0.
- IDLE: start=1 → SENSE.
- DONE: start=1 → reload pos, orientacao and passos, clear chegou, timeout and pend → SENSE. Otherwise hold.
- SENSE: register head, lateral, barreira and under → DECIDE.
- DECIDE evaluates the registered sensors with fixed priority; the first matching rule applies:
  1. under=1 → chegou=1, go to DONE.
  2. passos==MAX_PASSOS → timeout=1, go to DONE.
  3. pend=1: clear pend. If head=0 → action ADV. Otherwise fall through to rules 4–7.
  4. head=1 and barreira=1 → action REM.
  5. lateral=0 → turn toward the follow side, set pend.
  6. head=0 → action ADV.
  7. Otherwise turn away from the follow side.
- Follow-side turn direction: sentido = LADO (left-hand turns ccw, right-hand turns cw). Opposite turn: sentido = ~LADO.
- DECIDE with an action → ACT. Registered updates at that edge:
  - Turn: cw → orientacao+1 mod 4; ccw → orientacao−1 mod 4.
  - ADV: N → y−1, S → y+1, E → x+1, W → x−1, each saturating at 0, COLS−1 or ROWS−1 (no wrap). passos+1 even when saturated.
  - REM: no state change.
- ACT: exactly one of avancar, girar or remover is high for this single cycle, with sentido valid alongside girar → SETTLE.
- SETTLE: counts SETTLE_CYC cycles → SENSE.
- ocupado=1 in SENSE, DECIDE, ACT and SETTLE.
- start is ignored while ocupado=1.

## Timing
- start sampled high in IDLE at edge k → SENSE in cycle k+1 → DECIDE k+2 → ACT k+3 (pulse and updated orientacao/pos visible) → SETTLE → SENSE at k+3+SETTLE_CYC+1.
- Action period is 3+SETTLE_CYC cycles (5 by default).
- Sensors matter only at the SENSE edge; changes at other times are ignored.
- chegou/timeout rise one cycle after DECIDE, together with ocupado falling.
- under and the step limit in the same DECIDE: chegou wins, timeout stays 0.
- Async reset mid-run: all outputs return to reset values immediately; a pulse is truncated, never extended.

## Test plan
- Reset: hold reset=0 → orientacao=ORI0, pos=(0,0), passos=0, all pulses 0, ocupado=0. Release; with start=0 the block stays IDLE.
- Corridor: ORI0=2 (S), lateral=1, head=0, start=1 → avancar pulse every 5 cycles, pos_y 0→1→2, passos increments. At pos_y=7, a further advance keeps pos_y=7 and passos=8.
- Left-hand opening, LADO=0, ORI0=0: lateral=0, head=0 → girar with sentido=0, orientacao 0→3. Next period avancar regardless of lateral, pos_x saturates at 0.
- Dead end: head=1, lateral=1, barreira=0, LADO=0, orientacao=0 → girar with sentido=1, orientacao=1. Repeat ×4 → orientacao wraps 3→0.
- Debris: head=1, barreira=1 → remover one cycle; orientacao and pos unchanged. Next SENSE with head=0 → avancar.
- Termination:
  - under=1 → DONE, chegou=1, ocupado=0.
  - MAX_PASSOS=3 with an open corridor → exactly 3 avancar, then timeout=1.
  - start in DONE → reload pos/orientacao and restart.
  - reset=0 during ACT → avancar drops the same cycle and the block is IDLE.

Source files
------------

// File: rtl/robo_controle.sv
// Wall-following maze navigation controller: one FSM sequences sense, decide,
// act and settle phases while tracking heading, grid position and step count.
module robo_controle #(
    parameter int unsigned COLS       = 8,
    parameter int unsigned ROWS       = 8,
    parameter int unsigned X0         = 0,
    parameter int unsigned Y0         = 0,
    parameter int unsigned ORI0       = 0,
    parameter int unsigned LADO       = 0,
    parameter int unsigned SETTLE_CYC = 2,
    parameter int unsigned PW         = 8,
    parameter int unsigned MAX_PASSOS = 255,
    localparam int unsigned XW        = $clog2(COLS),
    localparam int unsigned YW        = $clog2(ROWS)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    input  logic          head,
    input  logic          lateral,
    input  logic          barreira,
    input  logic          under,
    output logic          avancar,
    output logic          girar,
    output logic          sentido,
    output logic          remover,
    output logic [1:0]    orientacao,
    output logic [XW-1:0] pos_x,
    output logic [YW-1:0] pos_y,
    output logic [PW-1:0] passos,
    output logic          ocupado,
    output logic          chegou,
    output logic          timeout
);

    localparam int unsigned CW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [XW-1:0] X_INI  = XW'(X0);
    localparam logic [YW-1:0] Y_INI  = YW'(Y0);
    localparam logic [XW-1:0] X_MAX  = XW'(COLS - 1);
    localparam logic [YW-1:0] Y_MAX  = YW'(ROWS - 1);
    localparam logic [1:0]    O_INI  = 2'(ORI0);
    localparam logic [PW-1:0] P_MAX  = PW'(MAX_PASSOS);
    localparam logic [CW-1:0] C_LAST = CW'(SETTLE_CYC - 1);
    localparam logic          LADO_B = (LADO != 0);

    typedef enum logic [2:0] {S_IDLE, S_SENSE, S_DECIDE, S_ACT, S_SETTLE, S_DONE} state_t;
    typedef enum logic [1:0] {A_ADV, A_TURN, A_REM} acao_t;

    state_t        state_q, state_d;
    acao_t         acao_q, acao_d;
    logic          sent_q, sent_d;
    logic [1:0]    ori_q, ori_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [PW-1:0] passos_q, passos_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pend_q, pend_d;
    logic          chegou_q, chegou_d;
    logic          timeout_q, timeout_d;
    logic          h_q, h_d, l_q, l_d, b_q, b_d, u_q, u_d;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            acao_q    <= A_ADV;
            sent_q    <= 1'b0;
            ori_q     <= O_INI;
            x_q       <= X_INI;
            y_q       <= Y_INI;
            passos_q  <= '0;
            cnt_q     <= '0;
            pend_q    <= 1'b0;
            chegou_q  <= 1'b0;
            timeout_q <= 1'b0;
            h_q       <= 1'b0;
            l_q       <= 1'b0;
            b_q       <= 1'b0;
            u_q       <= 1'b0;
        end else begin
            state_q   <= state_d;
            acao_q    <= acao_d;
            sent_q    <= sent_d;
            ori_q     <= ori_d;
            x_q       <= x_d;
            y_q       <= y_d;
            passos_q  <= passos_d;
            cnt_q     <= cnt_d;
            pend_q    <= pend_d;
            chegou_q  <= chegou_d;
            timeout_q <= timeout_d;
            h_q       <= h_d;
            l_q       <= l_d;
            b_q       <= b_d;
            u_q       <= u_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        acao_d    = acao_q;
        sent_d    = sent_q;
        ori_d     = ori_q;
        x_d       = x_q;
        y_d       = y_q;
        passos_d  = passos_q;
        cnt_d     = cnt_q;
        pend_d    = pend_q;
        chegou_d  = chegou_q;
        timeout_d = timeout_q;
        h_d       = h_q;
        l_d       = l_q;
        b_d       = b_q;
        u_d       = u_q;
        case (state_q)
            S_IDLE: if (start) state_d = S_SENSE;
            S_DONE: begin
                if (start) begin
                    state_d   = S_SENSE;
                    ori_d     = O_INI;
                    x_d       = X_INI;
                    y_d       = Y_INI;
                    passos_d  = '0;
                    pend_d    = 1'b0;
                    chegou_d  = 1'b0;
                    timeout_d = 1'b0;
                end
            end
            S_SENSE: begin
                h_d     = head;
                l_d     = lateral;
                b_d     = barreira;
                u_d     = under;
                state_d = S_DECIDE;
            end
            S_DECIDE: begin
                if (u_q) begin
                    chegou_d = 1'b1;
                    state_d  = S_DONE;
                end else if (passos_q == P_MAX) begin
                    timeout_d = 1'b1;
                    state_d   = S_DONE;
                end else begin
                    state_d = S_ACT;
                    // A pending follow-side turn is consumed by this decision; it
                    // forces an advance only when the way ahead is clear.
                    pend_d  = 1'b0;
                    if (pend_q && !h_q) begin
                        acao_d = A_ADV;
                    end else if (h_q && b_q) begin
                        acao_d = A_REM;
                    end else if (!l_q) begin
                        acao_d = A_TURN;
                        sent_d = LADO_B;
                        pend_d = 1'b1;
                    end else if (!h_q) begin
                        acao_d = A_ADV;
                    end else begin
                        acao_d = A_TURN;
                        sent_d = ~LADO_B;
                    end
                    if (acao_d == A_TURN) begin
                        ori_d = sent_d ? ori_q + 2'd1 : ori_q - 2'd1;
                    end else if (acao_d == A_ADV) begin
                        passos_d = passos_q + PW'(1);
                        case (ori_q)
                            2'd0:    if (y_q != '0)    y_d = y_q - YW'(1);
                            2'd1:    if (x_q != X_MAX) x_d = x_q + XW'(1);
                            2'd2:    if (y_q != Y_MAX) y_d = y_q + YW'(1);
                            default: if (x_q != '0)    x_d = x_q - XW'(1);
                        endcase
                    end
                end
            end
            S_ACT: begin
                cnt_d   = '0;
                state_d = S_SETTLE;
            end
            S_SETTLE: begin
                if (cnt_q == C_LAST) state_d = S_SENSE;
                else                 cnt_d   = cnt_q + CW'(1);
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign avancar    = (state_q == S_ACT) && (acao_q == A_ADV);
    assign girar      = (state_q == S_ACT) && (acao_q == A_TURN);
    assign remover    = (state_q == S_ACT) && (acao_q == A_REM);
    assign sentido    = girar && sent_q;
    assign ocupado    = (state_q == S_SENSE) || (state_q == S_DECIDE) ||
                        (state_q == S_ACT)   || (state_q == S_SETTLE);
    assign orientacao = ori_q;
    assign pos_x      = x_q;
    assign pos_y      = y_q;
    assign passos     = passos_q;
    assign chegou     = chegou_q;
    assign timeout    = timeout_q;

endmodule

// File: tb/tb_robo_controle.sv
// Bench for robo_controle: directed vector table, hand sequences for restart,
// priority and reset corners, then random sensor periods against a grid model.
module tb_robo_controle;

    localparam int COLS_P = 8;
    localparam int ROWS_P = 8;
    localparam int LADO_P = 0;
    localparam int MAXP   = 14;

    logic       clock, reset, start, head, lateral, barreira, under;
    logic       avancar, girar, sentido, remover, ocupado, chegou, timeout;
    logic [1:0] orientacao;
    logic [2:0] pos_x, pos_y;
    logic [7:0] passos;

    robo_controle #(
        .COLS(8), .ROWS(8), .X0(0), .Y0(0), .ORI0(0), .LADO(LADO_P),
        .SETTLE_CYC(2), .PW(8), .MAX_PASSOS(MAXP)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .head(head),
        .lateral(lateral), .barreira(barreira), .under(under),
        .avancar(avancar), .girar(girar), .sentido(sentido), .remover(remover),
        .orientacao(orientacao), .pos_x(pos_x), .pos_y(pos_y), .passos(passos),
        .ocupado(ocupado), .chegou(chegou), .timeout(timeout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        bit h, l, b, u;
        bit av, gi, se, re;
        bit term, chg, tmo;
        int ori, x, y, p;
    } vec_t;

    int n_tests = 0;
    int n_fail  = 0;

    // Grid model: heading 0..3 = N,E,S,W; coordinates as plain integers
    int m_x, m_y, m_ori, m_passos;
    bit m_pend, m_done;
    int dx[4] = '{0, 1, 0, -1};
    int dy[4] = '{-1, 0, 1, 0};

    function automatic vec_t mk(bit h, bit l, bit b, bit u, bit av, bit gi, bit se, bit re,
                                bit term, bit chg, bit tmo, int ori, int x, int y, int p);
        vec_t v;
        v.h = h; v.l = l; v.b = b; v.u = u;
        v.av = av; v.gi = gi; v.se = se; v.re = re;
        v.term = term; v.chg = chg; v.tmo = tmo;
        v.ori = ori; v.x = x; v.y = y; v.p = p;
        return v;
    endfunction

    function automatic int clamp(int v, int hi);
        return (v < 0) ? 0 : ((v > hi) ? hi : v);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reload();
        m_x = 0; m_y = 0; m_ori = 0; m_passos = 0; m_pend = 0; m_done = 0;
    endtask

    task automatic model_decide(input bit h, input bit l, input bit b, input bit u, output vec_t v);
        int act;
        bit cw;
        v = mk(h, l, b, u, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        if (u) begin
            m_done = 1; v.term = 1; v.chg = 1;
        end else if (m_passos == MAXP) begin
            m_done = 1; v.term = 1; v.tmo = 1;
        end else begin
            if (m_pend && !h)  act = 0;
            else if (h && b)   act = 1;
            else if (!l)       act = 2;
            else if (!h)       act = 0;
            else               act = 3;
            m_pend = (act == 2);
            if (act == 0) begin
                m_x = clamp(m_x + dx[m_ori], COLS_P - 1);
                m_y = clamp(m_y + dy[m_ori], ROWS_P - 1);
                m_passos++;
                v.av = 1;
            end else if (act == 1) begin
                v.re = 1;
            end else begin
                cw = (act == 2) ? (LADO_P != 0) : (LADO_P == 0);
                m_ori = (m_ori + (cw ? 1 : 3)) % 4;
                v.gi = 1;
                v.se = cw;
            end
        end
        v.ori = m_ori; v.x = m_x; v.y = m_y; v.p = m_passos;
    endtask

    // Entered #1 after the edge that put the DUT in IDLE/DONE; leaves it in SENSE.
    task automatic do_start();
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        model_reload();
    endtask

    // Entered #1 into a SENSE cycle; leaves #1 into the next SENSE or into DONE.
    task automatic run_period(input vec_t v, input string tag);
        head = v.h; lateral = v.l; barreira = v.b; under = v.u;
        start = 1'($urandom_range(0, 1));
        @(posedge clock); #1;
        head = 1'($urandom); lateral = 1'($urandom);
        barreira = 1'($urandom); under = 1'($urandom);
        @(posedge clock); #1;
        start = 1'b0;
        chk({tag, ".avancar"}, int'(avancar), int'(v.av));
        chk({tag, ".girar"},   int'(girar),   int'(v.gi));
        chk({tag, ".remover"}, int'(remover), int'(v.re));
        if (v.gi) chk({tag, ".sentido"}, int'(sentido), int'(v.se));
        chk({tag, ".ori"},     int'(orientacao), v.ori);
        chk({tag, ".x"},       int'(pos_x),   v.x);
        chk({tag, ".y"},       int'(pos_y),   v.y);
        chk({tag, ".passos"},  int'(passos),  v.p);
        chk({tag, ".ocupado"}, int'(ocupado), int'(!v.term));
        chk({tag, ".chegou"},  int'(chegou),  int'(v.chg));
        chk({tag, ".timeout"}, int'(timeout), int'(v.tmo));
        if (!v.term) begin
            @(posedge clock); #1;
            chk({tag, ".pulse_end"}, int'(avancar | girar | remover), 0);
            @(posedge clock); #1;
            @(posedge clock); #1;
        end
    endtask

    vec_t tbl[25];
    vec_t v;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; start = 1'b0;
        head = 1'b0; lateral = 1'b0; barreira = 1'b0; under = 1'b0;
        m_done = 1;

        //            h  l  b  u  av gi se re  T  C  O  ori x  y  p
        tbl[0]  = mk(0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        tbl[1]  = mk(1, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1, 0, 0, 1);
        tbl[2]  = mk(1, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 2, 0, 0, 1);
        tbl[3]  = mk(1, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 3, 0, 0, 1);
        tbl[4]  = mk(1, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1);
        tbl[5]  = mk(1, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1, 0, 0, 1);
        tbl[6]  = mk(0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 2);
        tbl[7]  = mk(1, 1, 1, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1, 0, 2);
        tbl[8]  = mk(0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 2, 0, 3);
        tbl[9]  = mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 2, 0, 3);
        tbl[10] = mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 2, 0, 4);
        tbl[11] = mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 3, 2, 0, 4);
        tbl[12] = mk(0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 3, 1, 0, 5);
        tbl[13] = mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 2, 1, 0, 5);
        tbl[14] = mk(1, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 2, 1, 0, 5);
        for (int i = 0; i < 8; i++)
            tbl[15 + i] = mk(0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 2, 1, (i < 7) ? i + 1 : 7, 6 + i);
        tbl[23] = mk(0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 2, 1, 7, 14);
        tbl[24] = mk(0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 1, 2, 1, 7, 14);

        repeat (2) @(posedge clock);
        #1;
        chk("rst.ori", int'(orientacao), 0);
        chk("rst.x", int'(pos_x), 0);
        chk("rst.y", int'(pos_y), 0);
        chk("rst.passos", int'(passos), 0);
        chk("rst.pulses", int'({avancar, girar, remover}), 0);
        chk("rst.ocupado", int'(ocupado), 0);
        chk("rst.flags", int'({chegou, timeout}), 0);
        @(negedge clock) reset = 1'b1;
        repeat (4) begin
            @(posedge clock); #1;
            chk("idle.ocupado", int'(ocupado), 0);
        end

        do_start();
        chk("start.ocupado", int'(ocupado), 1);
        for (int unsigned i = 0; i < 25; i++)
            run_period(tbl[i], $sformatf("vec%0d", i));

        do_start();
        chk("restart.ocupado", int'(ocupado), 1);
        chk("restart.ori", int'(orientacao), 0);
        chk("restart.pos", int'({pos_x, pos_y}), 0);
        chk("restart.passos", int'(passos), 0);
        chk("restart.flags", int'({chegou, timeout}), 0);
        repeat (MAXP) begin
            model_decide(0, 1, 0, 0, v);
            run_period(v, "fill");
        end
        model_decide(0, 1, 0, 1, v);
        run_period(v, "chegou_wins");
        chk("chegou_wins.passos", int'(passos), MAXP);

        do_start();
        head = 1'b0; lateral = 1'b1; barreira = 1'b0; under = 1'b0;
        @(posedge clock); #1;
        @(posedge clock); #1;
        chk("rstact.avancar_before", int'(avancar), 1);
        reset = 1'b0;
        #1;
        chk("rstact.avancar", int'(avancar), 0);
        chk("rstact.ocupado", int'(ocupado), 0);
        chk("rstact.passos", int'(passos), 0);
        chk("rstact.pos", int'({pos_x, pos_y}), 0);
        @(negedge clock) reset = 1'b1;
        repeat (3) begin
            @(posedge clock); #1;
            chk("rstact.idle", int'({ocupado, avancar}), 0);
        end
        m_done = 1;

        for (int unsigned i = 0; i < 300; i++) begin
            if (m_done) do_start();
            model_decide(1'($urandom), 1'($urandom), 1'($urandom),
                         ($urandom_range(0, 24) == 0), v);
            run_period(v, $sformatf("rnd%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
